// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM states and the single-cycle ALU function for alu_seq.
// ALU_SEQ_DIV_EN adds the DIV state and enables the iterative divider.
package alu_seq_pkg;

    // Single-cycle results are computed at this width and truncated by the caller.
    localparam int ALU_MAX_W = 64;

    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_CMP  = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_DIVU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_SLLV = 4'b1110;
    localparam logic [3:0] OP_SRLV = 4'b1111;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef ALU_SEQ_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [ALU_MAX_W-1:0] result;
        logic                 overflow;
        logic                 illegal;
    } single_res_t;

    // Operands arrive zero-extended; only the low 'width' bits of result are meaningful.
    function automatic single_res_t alu_single(
        input logic [3:0]           op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input logic [ALU_MAX_W-1:0] shamt,
        input logic [ALU_MAX_W-1:0] width
    );
        logic [ALU_MAX_W-1:0] sign_mask;
        logic [ALU_MAX_W-1:0] addend;
        logic [ALU_MAX_W-1:0] sum;
        single_res_t          r;
        sign_mask = ALU_MAX_W'(1) << (width - ALU_MAX_W'(1));
        addend    = (op == OP_ADD) ? b : (~b + ALU_MAX_W'(1));
        sum       = a + addend;
        r         = '0;
        case (op)
            OP_AND: r.result = a & b;
            OP_ADD, OP_SUB, OP_CMP: begin
                r.result   = sum;
                r.overflow = (((a ^ addend) & sign_mask) == '0) &&
                             (((sum ^ a) & sign_mask) != '0);
            end
            OP_BEQ:  r.result = (a == b) ? '0 : ALU_MAX_W'(1);
            OP_SLL:  r.result = a << shamt;
            OP_SRL:  r.result = a >> shamt;
            OP_SLLV: r.result = (b >= width) ? '0 : (a << b);
            OP_SRLV: r.result = (b >= width) ? '0 : (a >> b);
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath: shift-add multiply and (with ALU_SEQ_DIV_EN) restoring divide.
// One step per cycle for WIDTH cycles; done_o marks the cycle whose lo_o/hi_o are final.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opd_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] load_lo;
    logic [WIDTH-1:0] load_opd;
    logic [WIDTH:0]   mul_sum;

    // Multiply: lo holds the multiplier and is shifted out while the product shifts in.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});

`ifdef ALU_SEQ_DIV_EN
    logic             mode_q;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH:0]   div_diff;

    assign load_lo  = (mode_i == MODE_DIV) ? a_i : b_i;
    assign load_opd = (mode_i == MODE_DIV) ? b_i : a_i;
    assign div_rem  = {hi_q, lo_q[WIDTH-1]};
    assign div_diff = div_rem - {1'b0, opd_q};

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (mode_q == MODE_DIV) begin
            if (div_rem >= {1'b0, opd_q}) begin
                hi_d = WIDTH'(div_diff);
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = WIDTH'(div_rem);
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_MUL;
        end else if (start_i) begin
            mode_q <= mode_i;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode_i;
    assign load_lo     = b_i;
    assign load_opd    = a_i;

    always_comb begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
`endif

    assign done_o = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            opd_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= load_lo;
            opd_q <= load_opd;
        end else if (run_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered multicycle ALU with start/done handshake; MUL/DIVU iterate over WIDTH cycles.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIVU responds as an illegal op.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               negative,
    output logic               overflow,
    output logic               illegal
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_hi_q;
    logic [WIDTH-1:0] result_hi_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             illegal_q;
    logic             illegal_d;

    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             iter_start;
    logic             iter_mode;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;
    single_res_t      single_res;

    assign single_res = alu_single(op, ALU_MAX_W'(a), ALU_MAX_W'(b),
                                   ALU_MAX_W'(shamt), ALU_MAX_W'(WIDTH));

    generate
        if (WIDTH < ALU_MAX_W) begin : g_trunc
            logic unused_single_hi;
            assign unused_single_hi = ^single_res.result[ALU_MAX_W-1:WIDTH];
        end
    endgenerate

    assign accept = start && (state_q == ST_IDLE);
    assign is_mul = (op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
    logic divz_q;

    assign is_div = (op == OP_DIVU);

    // Divide-by-zero is flagged from the operand captured at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divz_q <= 1'b0;
        end else if (accept && is_div) begin
            divz_q <= (b == '0);
        end
    end
`else
    assign is_div = 1'b0;
`endif

    assign iter_start = accept && (is_mul || is_div);
    assign iter_mode  = is_div ? MODE_DIV : MODE_MUL;

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (iter_start),
        .mode_i  (iter_mode),
        .a_i     (a),
        .b_i     (b),
        .done_o  (iter_done),
        .lo_o    (iter_lo),
        .hi_o    (iter_hi)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = ST_MUL;
`ifdef ALU_SEQ_DIV_EN
                    end else if (is_div) begin
                        state_d = ST_DIV;
`endif
                    end else begin
                        result_d    = single_res.result[WIDTH-1:0];
                        result_hi_d = '0;
                        overflow_d  = single_res.overflow;
                        illegal_d   = single_res.illegal;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                if (iter_done) begin
                    result_d    = iter_lo;
                    result_hi_d = iter_hi;
                    overflow_d  = (iter_hi != '0);
                    illegal_d   = 1'b0;
                    state_d     = ST_DONE;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
                if (iter_done) begin
                    result_d    = iter_lo;
                    result_hi_d = iter_hi;
                    overflow_d  = divz_q;
                    illegal_d   = 1'b0;
                    state_d     = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
        end
    end

`ifdef ALU_SEQ_DIV_EN
    assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
`else
    assign busy = (state_q == ST_MUL);
`endif
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = (result_q == '0);
    assign negative  = result_q[WIDTH-1];
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed plan vectors, randomized ops against a
// 64-bit arithmetic reference model, start-ignore and reset-abandon scenarios.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [4:0]   shamt = '0;
    logic         busy, done, zero, negative, overflow, illegal;
    logic [W-1:0] result, result_hi;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         ov;
        logic         ill;
        int           lat;
    } exp_t;

    // Reference model: plain 64-bit arithmetic straight from the op definitions.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic [4:0] sh);
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint unsigned m  = 64'hFFFF_FFFF;
        longint unsigned nb = ((~uy) + 64'd1) & m;
        longint unsigned t  = 0;
        exp_t e;
        e.res = '0; e.hi = '0; e.ov = 1'b0; e.ill = 1'b0; e.lat = 1;
        case (o)
            4'b0001: e.res = x & y;
            4'b0010: begin
                t = (ux + uy) & m;
                e.res = t[W-1:0];
                e.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
            end
            4'b0011, 4'b0100: begin
                t = (ux + nb) & m;
                e.res = t[W-1:0];
                e.ov = (x[W-1] == nb[W-1]) && (t[W-1] != x[W-1]);
            end
            4'b0101: e.res = (x == y) ? 32'd0 : 32'd1;
            4'b0110: begin
                t = ux * uy;
                e.res = t[W-1:0];
                e.hi = t[2*W-1:W];
                e.ov = (e.hi != 0);
                e.lat = W + 1;
            end
`ifdef ALU_SEQ_DIV_EN
            4'b0111: begin
                if (y == 0) begin
                    e.res = '1; e.hi = x; e.ov = 1'b1;
                end else begin
                    e.res = x / y; e.hi = x % y;
                end
                e.lat = W + 1;
            end
`endif
            4'b1100: begin t = (ux << sh) & m; e.res = t[W-1:0]; end
            4'b1101: e.res = x >> sh;
            4'b1110: begin t = (uy >= W) ? 64'd0 : ((ux << uy) & m); e.res = t[W-1:0]; end
            4'b1111: begin t = (uy >= W) ? 64'd0 : (ux >> uy); e.res = t[W-1:0]; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Called at a negedge; pulses start and counts cycles until done (bounded).
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [4:0] sh, output int lat);
        op = o; a = x; b = y; shamt = sh; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, result, result_hi, zero, negative, overflow, illegal} !==
            {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state got busy=%b done=%b res=%h hi=%h z=%b n=%b ov=%b ill=%b want 0 0 0 0 1 0 0 0",
                     busy, done, result, result_hi, zero, negative, overflow, illegal);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'b0010, 32'd1, 32'd1, 5'd0, lat);
        @(negedge clk);
        op = 4'b0110; a = 32'h1234_5678; b = 32'h0000_0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || result !== 32'd2) begin
            n_bad++;
            $display("FAIL mid_mul_hold got busy=%b res=%h want busy=1 res=00000002", busy, result);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_mul got busy=%b done=%b res=%h z=%b want 0 0 00000000 1",
                     busy, done, result, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'b0010, 32'd1, 32'd1, 5'd0, lat);
        n_cmp++;
        if (result !== 32'd2 || lat !== 1) begin
            n_bad++;
            $display("FAIL add_after_reset got res=%h lat=%0d want 00000002 lat=1", result, lat);
        end
        $display("reset: ADD 1+1 after mid-MUL reset -> res=%h lat=%0d", result, lat);
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [3:0]   d_op [10] = '{4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b0111,
                                    4'b1110, 4'b1101, 4'b0101, 4'b1010, 4'b0100};
        logic [W-1:0] d_a  [10] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd100, 32'd9,
                                    32'd1, 32'h8000_0000, 32'd3, 32'hDEAD_BEEF, 32'd3};
        logic [W-1:0] d_b  [10] = '{32'd1, 32'd5, 32'd2, 32'd7, 32'd0,
                                    32'd32, 32'd0, 32'd3, 32'h1234_5678, 32'd9};
        logic [4:0]   d_sh [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                    5'd0, 5'd31, 5'd0, 5'd0, 5'd0};
        exp_t e;
        int lat;
        for (int i = 0; i < 10; i++) begin
            e = model(d_op[i], d_a[i], d_b[i], d_sh[i]);
            run_op(d_op[i], d_a[i], d_b[i], d_sh[i], lat);
            $display("directed %0d: op=%b a=%h b=%h -> res=%h hi=%h ov=%b ill=%b lat=%0d",
                     i, d_op[i], d_a[i], d_b[i], result, result_hi, overflow, illegal, lat);
            n_cmp++;
            if (lat !== e.lat) begin
                n_bad++; $display("FAIL dir%0d.latency got %0d want %0d", i, lat, e.lat);
            end
            n_cmp++;
            if (result !== e.res || result_hi !== e.hi) begin
                n_bad++; $display("FAIL dir%0d.result got %h:%h want %h:%h", i, result_hi, result, e.hi, e.res);
            end
            n_cmp++;
            if (overflow !== e.ov || illegal !== e.ill) begin
                n_bad++; $display("FAIL dir%0d.flags got ov=%b ill=%b want ov=%b ill=%b", i, overflow, illegal, e.ov, e.ill);
            end
            n_cmp++;
            if (zero !== (e.res == 0) || negative !== e.res[W-1]) begin
                n_bad++; $display("FAIL dir%0d.zn got z=%b n=%b want z=%b n=%b", i, zero, negative, e.res == 0, e.res[W-1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] x = $urandom;
        logic [W-1:0] y = $urandom;
        logic [W-1:0] prev_res;
        exp_t e;
        int lat;
        bit held = 1'b1;
        run_op(4'b0010, 32'd40, 32'd2, 5'd0, lat);
        @(negedge clk);
        prev_res = 32'd42;
        e = model(4'b0110, x, y, 5'd0);
        op = 4'b0110; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (result !== prev_res) held = 1'b0;
            if (lat == 5) begin
                op = 4'b0010; a = 32'd1; b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) lat = -1;
        $display("ignore_start: MUL a=%h b=%h -> res=%h hi=%h lat=%0d", x, y, result, result_hi, lat);
        n_cmp++;
        if (lat !== W + 1) begin
            n_bad++; $display("FAIL ignore.latency got %0d want %0d", lat, W + 1);
        end
        n_cmp++;
        if (result !== e.res || result_hi !== e.hi) begin
            n_bad++; $display("FAIL ignore.result got %h:%h want %h:%h", result_hi, result, e.hi, e.res);
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_bad++; $display("FAIL ignore.hold got held=%b want 1", held);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] want;
        bit want_done;
        for (int k = 0; k < 6; k++) begin
            op = 4'b0010; a = 32'(k * 3 + 1); b = 32'd100; start = 1'b1;
            want = 32'(k * 3 + 101);
            want_done = (k % 2 == 0);
            @(negedge clk);
            $display("back_to_back %0d: done=%b res=%h", k, done, result);
            n_cmp++;
            if (done !== want_done || (want_done && result !== want)) begin
                n_bad++;
                $display("FAIL b2b%0d got done=%b res=%h want done=%b res=%h", k, done, result, want_done, want);
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0]   o;
        logic [W-1:0] x, y;
        logic [4:0]   sh;
        exp_t e;
        int lat;
        for (int i = 0; i < 150; i++) begin
            o  = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            sh = 5'($urandom);
            e  = model(o, x, y, sh);
            run_op(o, x, y, sh, lat);
            $display("random %0d: op=%b a=%h b=%h sh=%0d -> res=%h hi=%h ov=%b ill=%b lat=%0d",
                     i, o, x, y, sh, result, result_hi, overflow, illegal, lat);
            n_cmp++;
            if (lat !== e.lat || result !== e.res || result_hi !== e.hi ||
                overflow !== e.ov || illegal !== e.ill || zero !== (e.res == 0) ||
                negative !== e.res[W-1]) begin
                n_bad++;
                $display("FAIL rnd%0d op=%b got %h:%h ov=%b ill=%b z=%b lat=%0d want %h:%h ov=%b ill=%b lat=%0d",
                         i, o, result_hi, result, overflow, illegal, zero, lat, e.hi, e.res, e.ov, e.ill, e.lat);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised-width ALU for the multicycle datapath. Successor to the combinational 32-bit ALU.
- Keeps the existing op encodings and flag semantics (zero, negative, overflow).
- Adds a start/done handshake and iterative unsigned multiply/divide executed over WIDTH cycles.
- Sits between the register-file operand latches (A/B) and the ALUOut register; the control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of 2.
- SHAMT_W, 5, shamt port width; must equal log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; operands and op sampled when start=1 and busy=0
- op  in  4  operation code (see Behaviour)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- shamt  in  SHAMT_W  immediate shift amount
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse; result and flags valid from this cycle
- result  out  WIDTH  low result / quotient
- result_hi  out  WIDTH  MUL high half / DIVU remainder; 0 for all other ops
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- overflow  out  1  per-op overflow (see Behaviour)
- illegal  out  1  op not implemented

Behaviour:
- Reset: async, active-low, any state. FSM goes to IDLE. busy, done, result, result_hi, overflow, illegal = 0; zero = 1; negative = 0. An in-flight MUL/DIVU is abandoned.
- Op codes:
  - AND=0001, ADD=0010, SUB=0011, CMP=0100, BEQ=0101
  - MUL=0110, DIVU=0111
  - SLL=1100, SRL=1101, SLLV=1110, SRLV=1111
  - All others are illegal.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + start, single-cycle op (incl. illegal): compute and register outputs, go to DONE. done=1 in the next cycle; latency 1.
  - IDLE + start, MUL: go to MUL, busy=1, iterate WIDTH cycles, then go to DONE. done at cycle WIDTH+1 after start.
  - IDLE + start, DIVU: go to DIV with the same timing as MUL.
  - DONE: done=1, busy=0, return to IDLE. start in DONE is ignored.
  - start while busy is ignored; no queueing.
- Outputs hold their last values until the next done. The internal iteration must not disturb result/result_hi until completion.
- ADD/SUB/CMP: two's-complement, truncated to WIDTH. overflow = signed overflow (operand signs equal, result sign differs; for SUB/CMP compare against ~b+1). SUB and CMP give identical results.
- BEQ: result = 0 if a==b, else 1; overflow 0.
- SLL/SRL: logical shifts of a by shamt.
- SLLV/SRLV: logical shifts of a by b. If b ≥ WIDTH (any upper bit set), result = 0.
- AND, shifts, BEQ: overflow = 0.
- MUL: unsigned shift-add, one partial product per cycle. {result_hi, result} = a*b; overflow = (result_hi != 0).
- DIVU: unsigned restoring division, one quotient bit per cycle. result = a/b, result_hi = a%b.
  - b==0: result = all ones, result_hi = a, overflow = 1. Still takes WIDTH+1 cycles.
- Illegal op: result = 0, result_hi = 0, overflow = 0, illegal = 1 with done after 1 cycle. illegal is cleared on the next accepted legal op.
- zero and negative are always derived from the registered result, including MUL/DIVU.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: DIVU is implemented as above.
- Undefined: no divider logic or DIV state; DIVU (0111) is treated as an illegal op (1-cycle done, illegal=1).

Decomposition:
- Package alu_seq_pkg: op-code localparams/enum, FSM state typedef, and a function computing single-cycle results and overflow.
- One natural sub-module: alu_seq_iter, the shared shift-add / restoring-subtract datapath with its iteration counter. It exposes start/mode/done internally; alu_seq owns the FSM and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-MUL at cycle 10 → next edge busy=0, done=0, result=0, zero=1. After release, start ADD 1+1 → result=2 one cycle later.
- ADD overflow: ADD 0x7FFFFFFF + 1 → done 1 cycle after start, result 0x80000000, overflow=1, negative=1. SUB 5-5 → result 0, zero=1, overflow=0.
- MUL: 0xFFFFFFFF × 2 → done exactly 33 cycles after start, result_hi=1, result=0xFFFFFFFE, overflow=1. A start pulse at cycle 5 is ignored.
- DIVU: 100 / 7 → result 14, result_hi 2, done at cycle 33. 9 / 0 → result 0xFFFFFFFF, result_hi 9, overflow=1.
- Shifts: SLLV a=1, b=32 → result 0. SRL a=0x80000000, shamt=31 → result 1. BEQ 3,3 → result 0, zero=1.
- Illegal op 1010 → illegal=1, result 0, done after 1 cycle. With ALU_SEQ_DIV_EN undefined, DIVU gives the same response.
